// File: rtl/inst_cycle_seq_if.sv
// Bus between the instruction-cycle sequencer and its neighbours: instruction memory,
// the branch-condition source, the external execute unit and status observers.
interface inst_cycle_seq_if #(
    parameter int OPW = 4,
    parameter int AW  = 8,
    parameter int SD  = 4
);
    localparam int CW = $clog2(SD + 1);

    logic               Enable;
    logic [OPW+AW-1:0]  MemData;
    logic               MemReady;
    logic               Cond;
    logic               ExecDone;

    logic [AW-1:0]      MemAddr;
    logic               MemRead;
    logic [OPW+AW-1:0]  IR;
    logic [OPW-1:0]     Opcode;
    logic [AW-1:0]      Operand;
    logic [AW-1:0]      PC;
    logic               ExecStrobe;
    logic               Halted;
    logic               StackErr;
    logic [CW-1:0]      StackCount;

    // Sequencer side
    modport slave (
        input  Enable, MemData, MemReady, Cond, ExecDone,
        output MemAddr, MemRead, IR, Opcode, Operand, PC,
               ExecStrobe, Halted, StackErr, StackCount
    );

    // Environment side
    modport master (
        output Enable, MemData, MemReady, Cond, ExecDone,
        input  MemAddr, MemRead, IR, Opcode, Operand, PC,
               ExecStrobe, Halted, StackErr, StackCount
    );
endinterface

// File: rtl/inst_cycle_seq.sv
// Instruction-cycle sequencer: IR, PC and return stack, stepping FETCH/DECODE/EXEC
// and resolving JMP, JC, CALL, RET and HALT without the external execute unit.
module inst_cycle_seq #(
    parameter int             OPW     = 4,
    parameter int             AW      = 8,
    parameter int             SD      = 4,
    parameter logic [OPW-1:0] OP_JMP  = 4'hC,
    parameter logic [OPW-1:0] OP_JC   = 4'hD,
    parameter logic [OPW-1:0] OP_CALL = 4'hE,
    parameter logic [OPW-1:0] OP_RET  = 4'hB,
    parameter logic [OPW-1:0] OP_HALT = 4'hF
) (
    input  logic                Clock,
    input  logic                Reset,
    inst_cycle_seq_if.slave     bus
);
    localparam int            CW        = $clog2(SD + 1);
    localparam logic [CW-1:0] STACKFULL = CW'(SD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t             stateReg, stateNext;
    logic [AW-1:0]      pcReg, pcNext;
    logic [OPW+AW-1:0]  irReg, irNext;
    logic [CW-1:0]      countReg, countNext;
    logic               errReg, errNext;
    logic               firstExecReg;
    logic               pushEn;

    logic [AW-1:0]      stackMem [SD];
    logic [SD-1:0]      slotWr;
    logic [AW-1:0]      topEntry;

    logic [OPW-1:0]     opcode;
    logic [AW-1:0]      operand;

    assign opcode  = irReg[OPW+AW-1:AW];
    assign operand = irReg[AW-1:0];

    // One write strobe per stack slot: a push lands at the current occupancy index.
    genvar gi;
    generate
        for (gi = 0; gi < SD; gi++) begin : gSlotWr
            assign slotWr[gi] = pushEn && (countReg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge Clock) begin
        for (int i = 0; i < SD; i++) begin
            if (slotWr[i]) begin
                stackMem[i] <= pcReg;
            end
        end
    end

    always_comb begin
        topEntry = '0;
        for (int i = 0; i < SD; i++) begin
            if (countReg == CW'(i + 1)) begin
                topEntry = stackMem[i];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg     <= S_IDLE;
            pcReg        <= '0;
            irReg        <= '0;
            countReg     <= '0;
            errReg       <= 1'b0;
            firstExecReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            irReg        <= irNext;
            countReg     <= countNext;
            errReg       <= errNext;
            firstExecReg <= (stateNext == S_EXEC) && (stateReg != S_EXEC);
        end
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        irNext    = irReg;
        countNext = countReg;
        errNext   = errReg;
        pushEn    = 1'b0;

        case (stateReg)
            S_IDLE: begin
                if (bus.Enable) begin
                    stateNext = S_FETCH;
                end
            end

            S_FETCH: begin
                if (bus.Enable && bus.MemReady) begin
                    irNext    = bus.MemData;
                    pcNext    = pcReg + AW'(1);
                    stateNext = S_DECODE;
                end
            end

            S_DECODE: begin
                // If-chain order sets priority when opcode parameters collide.
                if (opcode == OP_JMP) begin
                    pcNext    = operand;
                    stateNext = S_FETCH;
                end else if (opcode == OP_JC) begin
                    if (bus.Cond) begin
                        pcNext = operand;
                    end
                    stateNext = S_FETCH;
                end else if (opcode == OP_CALL) begin
                    if (countReg == STACKFULL) begin
                        errNext   = 1'b1;
                        stateNext = S_HALT;
                    end else begin
                        pushEn    = 1'b1;
                        countNext = countReg + CW'(1);
                        pcNext    = operand;
                        stateNext = S_FETCH;
                    end
                end else if (opcode == OP_RET) begin
                    if (countReg == '0) begin
                        errNext   = 1'b1;
                        stateNext = S_HALT;
                    end else begin
                        pcNext    = topEntry;
                        countNext = countReg - CW'(1);
                        stateNext = S_FETCH;
                    end
                end else if (opcode == OP_HALT) begin
                    stateNext = S_HALT;
                end else begin
                    stateNext = S_EXEC;
                end
            end

            S_EXEC: begin
                if (bus.ExecDone) begin
                    stateNext = S_FETCH;
                end
            end

            S_HALT: begin
                stateNext = S_HALT;
            end

            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    assign bus.MemAddr    = (stateReg == S_EXEC) ? operand : pcReg;
    assign bus.MemRead    = (stateReg == S_FETCH) && bus.Enable;
    assign bus.IR         = irReg;
    assign bus.Opcode     = opcode;
    assign bus.Operand    = operand;
    assign bus.PC         = pcReg;
    assign bus.ExecStrobe = (stateReg == S_EXEC) && firstExecReg;
    assign bus.Halted     = (stateReg == S_HALT);
    assign bus.StackErr   = errReg;
    assign bus.StackCount = countReg;
endmodule

// File: tb/tb_inst_cycle_seq.sv
// Cycle-by-cycle vector table for inst_cycle_seq plus a hand-written long-EXEC sequence.
module tb_inst_cycle_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inst_cycle_seq_if #(.OPW(4), .AW(8), .SD(4)) bus();

    inst_cycle_seq #(.OPW(4), .AW(8), .SD(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        r, e, y, c, d;
        logic [11:0] data;
        logic [7:0]  pc;
        logic [11:0] ir;
        logic [7:0]  addr;
        logic        rd, stb, h, er;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input string nm, input logic r, e, y, c, d, input logic [11:0] dat,
                       input logic [7:0] pc, input logic [11:0] ir, input logic [7:0] ad,
                       input logic rd, stb, h, er, input logic [2:0] cnt);
        vec_t v;
        v.name = nm; v.r = r; v.e = e; v.y = y; v.c = c; v.d = d; v.data = dat;
        v.pc = pc; v.ir = ir; v.addr = ad; v.rd = rd; v.stb = stb; v.h = h; v.er = er; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fpc;
        logic [46:0] act, exp;
        int          n;
        int          k;

        bus.Enable = 0; bus.MemData = '0; bus.MemReady = 0; bus.Cond = 0; bus.ExecDone = 0;

        //  name           r  e  y  c  d  data    pc     ir       addr   rd stb h  er cnt
        add("reset",       1, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        add("idle2fetch",  0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 0, 0, 0, 0);
        add("fetch123",    0, 1, 1, 0, 0, 12'h123, 8'h01, 12'h123, 8'h01, 0, 0, 0, 0, 0);
        add("dec2exec",    0, 1, 0, 0, 0, 12'h000, 8'h01, 12'h123, 8'h23, 0, 1, 0, 0, 0);
        add("execWait",    0, 1, 0, 0, 0, 12'h000, 8'h01, 12'h123, 8'h23, 0, 0, 0, 0, 0);
        add("execDone",    0, 1, 0, 0, 1, 12'h000, 8'h01, 12'h123, 8'h01, 1, 0, 0, 0, 0);
        add("fetchJmp",    0, 1, 1, 0, 0, 12'hC40, 8'h02, 12'hC40, 8'h02, 0, 0, 0, 0, 0);
        add("jmp",         0, 1, 0, 0, 0, 12'h000, 8'h40, 12'hC40, 8'h40, 1, 0, 0, 0, 0);
        add("fetchJc0",    0, 1, 1, 0, 0, 12'hD20, 8'h41, 12'hD20, 8'h41, 0, 0, 0, 0, 0);
        add("jcNotTaken",  0, 1, 0, 0, 0, 12'h000, 8'h41, 12'hD20, 8'h41, 1, 0, 0, 0, 0);
        add("fetchJc1",    0, 1, 1, 0, 0, 12'hD20, 8'h42, 12'hD20, 8'h42, 0, 0, 0, 0, 0);
        add("jcTaken",     0, 1, 0, 1, 0, 12'h000, 8'h20, 12'hD20, 8'h20, 1, 0, 0, 0, 0);
        add("fetchCall",   0, 1, 1, 0, 0, 12'hE10, 8'h21, 12'hE10, 8'h21, 0, 0, 0, 0, 0);
        add("call",        0, 1, 0, 0, 0, 12'h000, 8'h10, 12'hE10, 8'h10, 1, 0, 0, 0, 1);
        add("fetchRet",    0, 1, 1, 0, 0, 12'hB00, 8'h11, 12'hB00, 8'h11, 0, 0, 0, 0, 1);
        add("ret",         0, 1, 0, 0, 0, 12'h000, 8'h21, 12'hB00, 8'h21, 1, 0, 0, 0, 0);
        add("pauseEn0",    0, 0, 0, 0, 0, 12'h000, 8'h21, 12'hB00, 8'h21, 0, 0, 0, 0, 0);
        add("pauseEn1",    0, 1, 0, 0, 0, 12'h000, 8'h21, 12'hB00, 8'h21, 1, 0, 0, 0, 0);
        add("readyNoEn",   0, 0, 1, 0, 0, 12'h777, 8'h21, 12'hB00, 8'h21, 0, 0, 0, 0, 0);
        add("fetchOp0",    0, 1, 1, 0, 0, 12'h0AB, 8'h22, 12'h0AB, 8'h22, 0, 0, 0, 0, 0);
        add("decIgnDone",  0, 1, 0, 0, 1, 12'h000, 8'h22, 12'h0AB, 8'hAB, 0, 1, 0, 0, 0);
        add("execImm",     0, 1, 0, 0, 1, 12'h000, 8'h22, 12'h0AB, 8'h22, 1, 0, 0, 0, 0);
        add("fetchHalt",   0, 1, 1, 0, 0, 12'hF00, 8'h23, 12'hF00, 8'h23, 0, 0, 0, 0, 0);
        add("halt",        0, 1, 0, 0, 0, 12'h000, 8'h23, 12'hF00, 8'h23, 0, 0, 1, 0, 0);
        add("haltIgnore",  0, 1, 1, 0, 1, 12'h123, 8'h23, 12'hF00, 8'h23, 0, 0, 1, 0, 0);
        add("haltReset",   1, 1, 1, 0, 1, 12'h123, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        add("wrapGo",      0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 0, 0, 0, 0);
        add("fetchJmpFF",  0, 1, 1, 0, 0, 12'hCFF, 8'h01, 12'hCFF, 8'h01, 0, 0, 0, 0, 0);
        add("jmpFF",       0, 1, 0, 0, 0, 12'h000, 8'hFF, 12'hCFF, 8'hFF, 1, 0, 0, 0, 0);
        add("fetchWrap",   0, 1, 1, 0, 0, 12'h0AA, 8'h00, 12'h0AA, 8'h00, 0, 0, 0, 0, 0);
        add("execAA",      0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h0AA, 8'hAA, 0, 1, 0, 0, 0);
        add("execHold",    0, 1, 1, 0, 0, 12'h555, 8'h00, 12'h0AA, 8'hAA, 0, 0, 0, 0, 0);
        add("execReset",   1, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        add("retGo",       0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 0, 0, 0, 0);
        add("fetchRetE",   0, 1, 1, 0, 0, 12'hB00, 8'h01, 12'hB00, 8'h01, 0, 0, 0, 0, 0);
        add("retUnder",    0, 1, 0, 0, 0, 12'h000, 8'h01, 12'hB00, 8'h01, 0, 0, 1, 1, 0);
        add("errReset",    1, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        add("nestGo",      0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 0, 0, 0, 0);
        add("fetchC30",    0, 1, 1, 0, 0, 12'hE30, 8'h01, 12'hE30, 8'h01, 0, 0, 0, 0, 0);
        add("call30",      0, 1, 0, 0, 0, 12'h000, 8'h30, 12'hE30, 8'h30, 1, 0, 0, 0, 1);
        add("fetchC50",    0, 1, 1, 0, 0, 12'hE50, 8'h31, 12'hE50, 8'h31, 0, 0, 0, 0, 1);
        add("call50",      0, 1, 0, 0, 0, 12'h000, 8'h50, 12'hE50, 8'h50, 1, 0, 0, 0, 2);
        add("fetchR1",     0, 1, 1, 0, 0, 12'hB00, 8'h51, 12'hB00, 8'h51, 0, 0, 0, 0, 2);
        add("ret1",        0, 1, 0, 0, 0, 12'h000, 8'h31, 12'hB00, 8'h31, 1, 0, 0, 0, 1);
        add("fetchR2",     0, 1, 1, 0, 0, 12'hB00, 8'h32, 12'hB00, 8'h32, 0, 0, 0, 0, 1);
        add("ret2",        0, 1, 0, 0, 0, 12'h000, 8'h01, 12'hB00, 8'h01, 1, 0, 0, 0, 0);
        add("ovfReset",    1, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        add("ovfGo",       0, 1, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            fpc = (i == 1) ? 8'h01 : 8'h11;
            add($sformatf("ovfFetch%0d", i), 0, 1, 1, 0, 0, 12'hE10, fpc, 12'hE10, fpc, 0, 0, 0, 0, 3'(i - 1));
            add($sformatf("ovfCall%0d", i),  0, 1, 0, 0, 0, 12'h000, 8'h10, 12'hE10, 8'h10, 1, 0, 0, 0, 3'(i));
        end
        add("ovfFetch5",   0, 1, 1, 0, 0, 12'hE10, 8'h11, 12'hE10, 8'h11, 0, 0, 0, 0, 4);
        add("ovfCall5",    0, 1, 0, 0, 0, 12'h000, 8'h11, 12'hE10, 8'h11, 0, 0, 1, 1, 4);
        add("ovfHold",     0, 1, 1, 0, 1, 12'hC00, 8'h11, 12'hE10, 8'h11, 0, 0, 1, 1, 4);
        add("finalReset",  1, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            bus.Enable = vecs[i].e; bus.MemReady = vecs[i].y; bus.Cond = vecs[i].c;
            bus.ExecDone = vecs[i].d; bus.MemData = vecs[i].data;
            step();
            act = {bus.PC, bus.IR, bus.MemAddr, bus.MemRead, bus.ExecStrobe, bus.Halted,
                   bus.StackErr, bus.StackCount, bus.Opcode, bus.Operand};
            exp = {vecs[i].pc, vecs[i].ir, vecs[i].addr, vecs[i].rd, vecs[i].stb, vecs[i].h,
                   vecs[i].er, vecs[i].cnt, vecs[i].ir[11:8], vecs[i].ir[7:0]};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL %s: got pc=%h ir=%h addr=%h rd=%b stb=%b halt=%b err=%b cnt=%0d op=%h opd=%h, want pc=%h ir=%h addr=%h rd=%b stb=%b halt=%b err=%b cnt=%0d",
                         vecs[i].name, bus.PC, bus.IR, bus.MemAddr, bus.MemRead, bus.ExecStrobe,
                         bus.Halted, bus.StackErr, bus.StackCount, bus.Opcode, bus.Operand,
                         vecs[i].pc, vecs[i].ir, vecs[i].addr, vecs[i].rd, vecs[i].stb,
                         vecs[i].h, vecs[i].er, vecs[i].cnt);
            end else begin
                $display("[TB] vec %-12s pc=%h ir=%h addr=%h ok", vecs[i].name, bus.PC, bus.IR, bus.MemAddr);
            end
        end

        // Long EXEC: strobe must pulse once however long ExecDone stays low.
        rst = 1; bus.Enable = 0; bus.MemReady = 0; bus.ExecDone = 0; bus.Cond = 0;
        step();
        rst = 0; bus.Enable = 1; bus.MemReady = 1; bus.MemData = 12'h0AB;
        step();
        step();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.ExecStrobe) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL longExecStrobe: got %0d pulses, want 1", n);
        end else begin
            $display("[TB] longExecStrobe pulses=%0d ok", n);
        end
        tests++;
        if (bus.IR !== 12'h0AB || bus.PC !== 8'h01 || bus.MemAddr !== 8'hAB) begin
            fails++;
            $display("FAIL longExecHold: got ir=%h pc=%h addr=%h, want ir=0ab pc=01 addr=ab",
                     bus.IR, bus.PC, bus.MemAddr);
        end else begin
            $display("[TB] longExecHold ir=%h pc=%h ok", bus.IR, bus.PC);
        end

        bus.ExecDone = 1;
        k = 0;
        while (k < 4) begin
            step();
            if (bus.MemRead) break;
            k++;
        end
        tests++;
        if (k != 0 || bus.MemAddr !== 8'h01) begin
            fails++;
            $display("FAIL execRelease: got extraCycles=%0d addr=%h, want 0 and 01", k, bus.MemAddr);
        end else begin
            $display("[TB] execRelease addr=%h ok", bus.MemAddr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
